// File: rtl/wb_pkg.sv
// Shared types and defaults for the write-back queue.
// WBQ_FWD_EN (see wb_write_queue) controls whether forwarding logic is built.
package wb_pkg;

   localparam int unsigned WB_DEPTH  = 4;
   localparam int unsigned WB_DATA_W = 16;
   localparam int unsigned WB_REG_W  = 4;

   typedef struct packed {
      logic [WB_REG_W-1:0]  rid;
      logic [WB_DATA_W-1:0] data;
   } wb_entry_t;

   // Width of a head/tail pointer for a power-of-two queue depth.
   function automatic int unsigned ptr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/wbq_fwd_match.sv
// Youngest-match search over queued entries for one register-file read port.
// Entries arrive age-ordered: index 0 is the head (oldest), higher indices are younger.
module wbq_fwd_match
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH  = WB_DEPTH,
   parameter int unsigned DATA_W = WB_DATA_W,
   parameter int unsigned REG_W  = WB_REG_W
) (
   input  logic [REG_W-1:0]        src_reg,
   input  logic [DEPTH-1:0]        age_valid,
   input  logic [DEPTH*REG_W-1:0]  age_rid,
   input  logic [DEPTH*DATA_W-1:0] age_dat,
   output logic                    hit,
   output logic [DATA_W-1:0]       data
);

   // Later (younger) matches override earlier ones.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (age_valid[i] && (age_rid[i*REG_W +: REG_W] == src_reg)) begin
            hit  = 1'b1;
            data = age_dat[i*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: rtl/wb_write_queue.sv
// Write-back queue: up to two enqueues per cycle, one drain per cycle to the register file.
// Define WBQ_FWD_EN to build the youngest-entry forwarding comparators; otherwise fwd_* read 0.
module wb_write_queue
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH  = WB_DEPTH,
   parameter int unsigned DATA_W = WB_DATA_W,
   parameter int unsigned REG_W  = WB_REG_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       mem_valid,
   input  logic [REG_W-1:0]           mem_reg,
   input  logic [DATA_W-1:0]          mem_data,
   input  logic                       alu_valid,
   input  logic [REG_W-1:0]           alu_reg,
   input  logic [DATA_W-1:0]          alu_data,
   output logic                       ready,
   output logic                       WriteReg,
   output logic [REG_W-1:0]           DstReg,
   output logic [DATA_W-1:0]          DstData,
   input  logic [REG_W-1:0]           SrcReg1,
   input  logic [REG_W-1:0]           SrcReg2,
   output logic                       fwd_hit1,
   output logic                       fwd_hit2,
   output logic [DATA_W-1:0]          fwd_data1,
   output logic [DATA_W-1:0]          fwd_data2,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow
);

   localparam int unsigned PTR_W = ptr_w(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [REG_W-1:0]  rid_q [DEPTH];
   logic [REG_W-1:0]  rid_d [DEPTH];
   logic [DATA_W-1:0] dat_q [DEPTH];
   logic [DATA_W-1:0] dat_d [DEPTH];
   logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              overflow_q, overflow_d;

   logic              pop, mem_acc, alu_acc;
   logic [CNT_W-1:0]  free_slots;
   logic [PTR_W-1:0]  alu_slot;

   assign pop      = (count_q != '0);
   assign WriteReg = pop;
   // Gated so stale slot contents never appear after a reset or once drained.
   assign DstReg   = pop ? rid_q[head_q] : '0;
   assign DstData  = pop ? dat_q[head_q] : '0;
   assign ready    = (count_q <= CNT_W'(DEPTH - 2));
   assign count    = count_q;
   assign overflow = overflow_q;

   always_comb begin
      // The head leaving this edge frees its slot for an incoming request.
      free_slots = CNT_W'(DEPTH) - count_q + CNT_W'(pop);
      mem_acc    = mem_valid && (free_slots != '0);
      alu_acc    = alu_valid && (free_slots > (mem_acc ? CNT_W'(1) : CNT_W'(0)));
      alu_slot   = mem_acc ? tail_q + PTR_W'(1) : tail_q;

      rid_d = rid_q;
      dat_d = dat_q;
      if (mem_acc) begin
         rid_d[tail_q] = mem_reg;
         dat_d[tail_q] = mem_data;
      end
      if (alu_acc) begin
         rid_d[alu_slot] = alu_reg;
         dat_d[alu_slot] = alu_data;
      end

      tail_d     = tail_q + PTR_W'(mem_acc) + PTR_W'(alu_acc);
      head_d     = head_q + PTR_W'(pop);
      count_d    = count_q + CNT_W'(mem_acc) + CNT_W'(alu_acc) - CNT_W'(pop);
      overflow_d = overflow_q | (mem_valid & ~mem_acc) | (alu_valid & ~alu_acc);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      rid_q <= rid_d;
      dat_q <= dat_d;
   end

`ifdef WBQ_FWD_EN
   logic [DEPTH-1:0]        age_valid;
   logic [DEPTH*REG_W-1:0]  age_rid;
   logic [DEPTH*DATA_W-1:0] age_dat;

   always_comb begin
      age_valid = '0;
      age_rid   = '0;
      age_dat   = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         age_valid[i]                = (CNT_W'(i) < count_q);
         age_rid[i*REG_W +: REG_W]   = rid_q[head_q + PTR_W'(i)];
         age_dat[i*DATA_W +: DATA_W] = dat_q[head_q + PTR_W'(i)];
      end
   end

   wbq_fwd_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W)) u_fwd1 (
      .src_reg   (SrcReg1),
      .age_valid (age_valid),
      .age_rid   (age_rid),
      .age_dat   (age_dat),
      .hit       (fwd_hit1),
      .data      (fwd_data1)
   );

   wbq_fwd_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W)) u_fwd2 (
      .src_reg   (SrcReg2),
      .age_valid (age_valid),
      .age_rid   (age_rid),
      .age_dat   (age_dat),
      .hit       (fwd_hit2),
      .data      (fwd_data2)
   );
`else
   logic unused_src;
   assign unused_src = ^{SrcReg1, SrcReg2};
   assign fwd_hit1   = 1'b0;
   assign fwd_hit2   = 1'b0;
   assign fwd_data1  = '0;
   assign fwd_data2  = '0;
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue (DEPTH=4): vector table plus hand-written corner sequences.
// Forwarding expectations are masked to zero when WBQ_FWD_EN is not defined.
module tb_wb_write_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid, alu_valid;
   logic [3:0]  mem_reg, alu_reg, SrcReg1, SrcReg2;
   logic [15:0] mem_data, alu_data;
   logic        ready, WriteReg, fwd_hit1, fwd_hit2, overflow;
   logic [3:0]  DstReg;
   logic [15:0] DstData, fwd_data1, fwd_data2;
   logic [2:0]  count;

`ifdef WBQ_FWD_EN
   localparam bit FWD_ON = 1'b1;
`else
   localparam bit FWD_ON = 1'b0;
`endif

   int n_vec  = 0;
   int n_miss = 0;

   wb_write_queue #(.DEPTH(4), .DATA_W(16), .REG_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_valid (mem_valid),
      .mem_reg   (mem_reg),
      .mem_data  (mem_data),
      .alu_valid (alu_valid),
      .alu_reg   (alu_reg),
      .alu_data  (alu_data),
      .ready     (ready),
      .WriteReg  (WriteReg),
      .DstReg    (DstReg),
      .DstData   (DstData),
      .SrcReg1   (SrcReg1),
      .SrcReg2   (SrcReg2),
      .fwd_hit1  (fwd_hit1),
      .fwd_hit2  (fwd_hit2),
      .fwd_data1 (fwd_data1),
      .fwd_data2 (fwd_data2),
      .count     (count),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        mv;
      logic [3:0]  mr;
      logic [15:0] md;
      logic        av;
      logic [3:0]  ar;
      logic [15:0] ad;
      logic [3:0]  s1;
      logic [3:0]  s2;
      logic        ew;
      logic [3:0]  edst;
      logic [15:0] edat;
      logic [2:0]  ecnt;
      logic        erdy;
      logic        eovf;
      logic        eh1;
      logic [15:0] ed1;
      logic        eh2;
      logic [15:0] ed2;
   } vec_t;

   function automatic vec_t v(
      input logic r, input logic mv, input logic [3:0] mr, input logic [15:0] md,
      input logic av, input logic [3:0] ar, input logic [15:0] ad,
      input logic [3:0] s1, input logic [3:0] s2,
      input logic ew, input logic [3:0] edst, input logic [15:0] edat,
      input logic [2:0] ecnt, input logic erdy, input logic eovf,
      input logic eh1, input logic [15:0] ed1, input logic eh2, input logic [15:0] ed2);
      vec_t t;
      t.rst = r;   t.mv = mv;   t.mr = mr;     t.md = md;
      t.av = av;   t.ar = ar;   t.ad = ad;     t.s1 = s1;  t.s2 = s2;
      t.ew = ew;   t.edst = edst; t.edat = edat; t.ecnt = ecnt;
      t.erdy = erdy; t.eovf = eovf;
      t.eh1 = eh1; t.ed1 = ed1; t.eh2 = eh2;   t.ed2 = ed2;
      return t;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      rst       = t.rst;
      mem_valid = t.mv;
      mem_reg   = t.mr;
      mem_data  = t.md;
      alu_valid = t.av;
      alu_reg   = t.ar;
      alu_data  = t.ad;
      SrcReg1   = t.s1;
      SrcReg2   = t.s2;
   endtask

   task automatic check_all(input vec_t t, input int idx);
      chk("WriteReg",  idx, 32'(WriteReg),  32'(t.ew));
      chk("DstReg",    idx, 32'(DstReg),    32'(t.edst));
      chk("DstData",   idx, 32'(DstData),   32'(t.edat));
      chk("count",     idx, 32'(count),     32'(t.ecnt));
      chk("ready",     idx, 32'(ready),     32'(t.erdy));
      chk("overflow",  idx, 32'(overflow),  32'(t.eovf));
      chk("fwd_hit1",  idx, 32'(fwd_hit1),  32'(t.eh1 & FWD_ON));
      chk("fwd_data1", idx, 32'(fwd_data1), FWD_ON ? 32'(t.ed1) : 32'd0);
      chk("fwd_hit2",  idx, 32'(fwd_hit2),  32'(t.eh2 & FWD_ON));
      chk("fwd_data2", idx, 32'(fwd_data2), FWD_ON ? 32'(t.ed2) : 32'd0);
   endtask

   vec_t vecs[25];

   initial begin
      //            rst mv mr  md       av ar  ad       s1 s2  ew dst dat      cnt rdy ovf h1 d1       h2 d2
      vecs[0]  = v(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,  0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 16'h0000);
      // single write, visible to forwarding the cycle after acceptance
      vecs[1]  = v(0, 1, 3, 16'hBEEF, 0, 0, 16'h0000, 3, 9,  1, 3, 16'hBEEF, 1, 1, 0, 1, 16'hBEEF, 0, 16'h0000);
      vecs[2]  = v(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 3, 9,  0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 16'h0000);
      // dual enqueue: mem first
      vecs[3]  = v(0, 1, 5, 16'h1111, 1, 6, 16'h2222, 0, 0,  1, 5, 16'h1111, 2, 1, 0, 0, 16'h0000, 0, 16'h0000);
      vecs[4]  = v(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,  1, 6, 16'h2222, 1, 1, 0, 0, 16'h0000, 0, 16'h0000);
      vecs[5]  = v(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,  0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 16'h0000);
      // fill / ready
      vecs[6]  = v(0, 1, 1, 16'h0A01, 1, 2, 16'h0A02, 0, 0,  1, 1, 16'h0A01, 2, 1, 0, 0, 16'h0000, 0, 16'h0000);
      vecs[7]  = v(0, 1, 3, 16'h0A03, 1, 4, 16'h0A04, 0, 0,  1, 2, 16'h0A02, 3, 0, 0, 0, 16'h0000, 0, 16'h0000);
      vecs[8]  = v(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,  1, 3, 16'h0A03, 2, 1, 0, 0, 16'h0000, 0, 16'h0000);
      vecs[9]  = v(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,  1, 4, 16'h0A04, 1, 1, 0, 0, 16'h0000, 0, 16'h0000);
      vecs[10] = v(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,  0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 16'h0000);
      // forwarding: youngest R7 wins, head included
      vecs[11] = v(0, 1, 7, 16'h0001, 1, 7, 16'h0002, 7, 9,  1, 7, 16'h0001, 2, 1, 0, 1, 16'h0002, 0, 16'h0000);
      vecs[12] = v(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 7, 9,  1, 7, 16'h0002, 1, 1, 0, 1, 16'h0002, 0, 16'h0000);
      vecs[13] = v(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 7, 9,  0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 16'h0000);
      vecs[14] = v(0, 1, 8, 16'h0808, 1, 9, 16'h0909, 8, 9,  1, 8, 16'h0808, 2, 1, 0, 1, 16'h0808, 1, 16'h0909);
      vecs[15] = v(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 8, 9,  1, 9, 16'h0909, 1, 1, 0, 0, 16'h0000, 1, 16'h0909);
      vecs[16] = v(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 8, 9,  0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 16'h0000);
      // overflow: fill to 4, then one accepted (pop frees a slot) and one dropped
      vecs[17] = v(0, 1, 1, 16'h0101, 1, 2, 16'h0202, 0, 0,  1, 1, 16'h0101, 2, 1, 0, 0, 16'h0000, 0, 16'h0000);
      vecs[18] = v(0, 1, 3, 16'h0303, 1, 4, 16'h0404, 0, 0,  1, 2, 16'h0202, 3, 0, 0, 0, 16'h0000, 0, 16'h0000);
      vecs[19] = v(0, 1, 5, 16'h0505, 1, 6, 16'h0606, 0, 0,  1, 3, 16'h0303, 4, 0, 0, 0, 16'h0000, 0, 16'h0000);
      vecs[20] = v(0, 1, 7, 16'h0707, 1, 8, 16'h0808, 0, 0,  1, 4, 16'h0404, 4, 0, 1, 0, 16'h0000, 0, 16'h0000);
      vecs[21] = v(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,  1, 5, 16'h0505, 3, 0, 1, 0, 16'h0000, 0, 16'h0000);
      vecs[22] = v(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,  1, 6, 16'h0606, 2, 1, 1, 0, 16'h0000, 0, 16'h0000);
      // reset with entries pending and a request presented: everything discarded
      vecs[23] = v(1, 1, 10, 16'h0A0A, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 16'h0000);
      vecs[24] = v(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,  0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 16'h0000);

      for (int i = 0; i < 25; i++) begin
         drive(vecs[i]);
         @(posedge clk);
         #1;
         check_all(vecs[i], i);
      end

      // R0 is queued normally; no combinational path from valid to WriteReg
      mem_valid = 1'b1; mem_reg = 4'd0; mem_data = 16'hFFFF;
      SrcReg1 = 4'd0; SrcReg2 = 4'd9;
      #1;
      chk("no_comb_WriteReg", 100, 32'(WriteReg), 32'd0);
      chk("no_comb_count",    100, 32'(count),    32'd0);
      @(posedge clk); #1;
      mem_valid = 1'b0;
      chk("r0_WriteReg", 101, 32'(WriteReg), 32'd1);
      chk("r0_DstReg",   101, 32'(DstReg),   32'd0);
      chk("r0_DstData",  101, 32'(DstData),  32'hFFFF);
      chk("r0_fwd_hit1", 101, 32'(fwd_hit1), 32'(FWD_ON));
      chk("r0_fwd_data1",101, 32'(fwd_data1), FWD_ON ? 32'hFFFF : 32'd0);
      @(posedge clk); #1;
      chk("r0_drained", 102, 32'(WriteReg), 32'd0);

      // reset on the edge right after a dual enqueue: no further writes afterwards
      mem_valid = 1'b1; mem_reg = 4'd11; mem_data = 16'hB0B0;
      alu_valid = 1'b1; alu_reg = 4'd12; alu_data = 16'hC0C0;
      @(posedge clk); #1;
      chk("pre_rst_count", 103, 32'(count), 32'd2);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; mem_valid = 1'b0; alu_valid = 1'b0;
      chk("rst_count",    104, 32'(count),    32'd0);
      chk("rst_WriteReg", 104, 32'(WriteReg), 32'd0);
      chk("rst_DstData",  104, 32'(DstData),  32'd0);
      chk("rst_ready",    104, 32'(ready),    32'd1);
      @(posedge clk); #1;
      chk("post_rst_WriteReg", 105, 32'(WriteReg), 32'd0);
      chk("post_rst_count",    105, 32'(count),    32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", n_miss);
      $fatal(1);
   end

endmodule

// File: doc/wb_write_queue.md
# wb_write_queue

Write-back queue that sits between the pipeline's write-back sources (ALU result and memory load) and the 16x16 register file's single write port. Accepts up to two register writes per cycle and drains one per cycle into the register file's DstReg/WriteReg/DstData inputs. Provides youngest-entry forwarding so decode reads see queued-but-unwritten values.

## Interface
- DEPTH, 4, queue entries; power of two, at least 2
- DATA_W, 16, register data width
- REG_W, 4, register-id width

- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- mem_valid  in  1  memory write-back request
- mem_reg  in  REG_W  destination register for the memory request
- mem_data  in  DATA_W  data for the memory request
- alu_valid  in  1  ALU write-back request
- alu_reg  in  REG_W  destination register for the ALU request
- alu_data  in  DATA_W  data for the ALU request
- ready  out  1  queue can accept two requests this cycle
- WriteReg  out  1  register-file write enable
- DstReg  out  REG_W  register-file write address
- DstData  out  DATA_W  register-file write data
- SrcReg1, SrcReg2  in  REG_W  register ids currently being read from the register file
- fwd_hit1, fwd_hit2  out  1  a queued entry matches SrcRegN
- fwd_data1, fwd_data2  out  DATA_W  data of the youngest matching entry
- count  out  clog2(DEPTH+1)  occupied entries
- overflow  out  1  sticky flag: a request was dropped

## Operation
- Circular buffer with head/tail pointers that wrap modulo DEPTH, plus an occupancy counter.
- Enqueue order in one cycle: the mem request is older and goes first, the ALU request goes second. A single valid request takes one slot.
- Drain: WriteReg = (count != 0); DstReg/DstData = head entry, combinational from state. The head pops at every edge where WriteReg=1.
- Count update: count_next = count + enqueued − popped. A cycle with two enqueues and one pop gives a net change of +1.
- ready = (count <= DEPTH−2), computed from current state only. The pop in the same cycle is not credited.
- When ready=0, producers must not assert valid. If they do, any request that finds no free slot is dropped, counting the same-cycle pop as freeing a slot, and overflow sets. overflow holds until rst.
- Forwarding: compare SrcRegN against all occupied entries. Return the youngest match, i.e. the entry nearest the tail. The head entry is included.
- Register 0 gets no special handling. Writes to R0 are queued like any other register.
- Reset values: count=0, WriteReg=0, DstReg=0, DstData=0, ready=1, fwd_hit1=fwd_hit2=0, fwd_data1=fwd_data2=0, overflow=0, pointers=0.

## Timing
- Enqueue-to-write latency:
  - A request accepted at edge N into an empty queue drives WriteReg=1 during cycle N..N+1.
  - The register file captures it at edge N+1.
- Requests are never written to the register file in the same cycle they are presented. No combinational path runs from *_valid to WriteReg.
- Forwarding is combinational from state and SrcRegN. An entry is visible to forwarding starting in the cycle after it is accepted, and stays visible through the cycle it drains.
- rst asserted mid-operation: all entries are discarded at that edge with no further register-file writes. All outputs take their reset values in the next cycle.

## Configuration
- WBQ_FWD_EN defined: the forwarding comparators and fwd_* outputs operate as described above.
- WBQ_FWD_EN undefined: no comparators are built, and fwd_hit1/2 and fwd_data1/2 are tied to 0. Queue and drain behaviour is unchanged.

## Structure
- Package wb_pkg holds:
  - typedef wb_entry_t {reg id, data}
  - default DEPTH, DATA_W and REG_W localparams
  - a pointer-width function
- Sub-module wbq_fwd_match performs the youngest-match priority search for one read port. It is instantiated twice, only under WBQ_FWD_EN.

## Test plan
- Single write, from reset: mem_valid=1, mem_reg=3, mem_data=16'hBEEF for one cycle.
  - Next cycle: WriteReg=1, DstReg=3, DstData=BEEF.
  - Cycle after that: WriteReg=0, count=0.
- Dual enqueue: mem (R5=0x1111) and alu (R6=0x2222) in the same cycle.
  - count goes 2 → 1 → 0.
  - Write order is R5 then R6.
- Fill/ready, DEPTH=4: two dual enqueues on consecutive cycles.
  - After the first, count=2 and ready=1.
  - After the second, count=3 (one pop) and ready=0.
  - The queue drains to 0 in 3 cycles with writes in FIFO order.
- Forwarding: enqueue R7=0x0001 then R7=0x0002, with SrcReg1=7.
  - fwd_hit1=1 and fwd_data1=0x0002 until the second entry drains.
  - With SrcReg2=9: fwd_hit2=0.
- Overflow: with count=4, assert both valids.
  - One request is accepted (pop frees a slot), the other is dropped.
  - overflow=1 and stays 1.
  - rst clears overflow and count, and WriteReg=0 in the next cycle.
